acc_requant_q88: RTL and testbench

- Requantisation stage directly upstream of the tanh activation.
- Takes the wide signed accumulator from the conv/MAC array, adds a per-channel Q8.8 bias, rounds and right-shifts to Q8.8, saturates to 16 bits, and presents the result to the activation input.
- Two-stage pipeline with valid/ready backpressure on both sides.
- Counts saturation events for quantisation-range debugging.

---
 rtl/acc_requant_q88_pkg.sv | 29 ++
 rtl/acc_requant_q88_if.sv | 31 +++
 rtl/acc_requant_q88_round_sat.sv | 37 +++
 rtl/acc_requant_q88.sv | 125 ++++++++++++
 tb/tb_acc_requant_q88.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/acc_requant_q88_pkg.sv
// Shared Q8.8 constants and saturation helpers for the requantisation and activation stages.
package acc_requant_q88_pkg;

    localparam int ACC_WIDTH_DEF  = 32;
    localparam int Q88_WIDTH      = 16;
    localparam int Q88_FRAC_BITS  = 8;
    localparam int SAT_IN_W       = 64;

    localparam logic [Q88_WIDTH-1:0] Q88_MAX = 16'h7FFF;
    localparam logic [Q88_WIDTH-1:0] Q88_MIN = 16'h8000;

    localparam logic signed [SAT_IN_W-1:0] Q88_HI_W = {{(SAT_IN_W-Q88_WIDTH){1'b0}}, Q88_MAX};
    localparam logic signed [SAT_IN_W-1:0] Q88_LO_W = {{(SAT_IN_W-Q88_WIDTH){1'b1}}, Q88_MIN};

    function automatic logic q88_clips(input logic signed [SAT_IN_W-1:0] x);
        return (x > Q88_HI_W) || (x < Q88_LO_W);
    endfunction

    function automatic logic [Q88_WIDTH-1:0] sat_q88(input logic signed [SAT_IN_W-1:0] x);
        if (x > Q88_HI_W) begin
            return Q88_MAX;
        end else if (x < Q88_LO_W) begin
            return Q88_MIN;
        end else begin
            return x[Q88_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/acc_requant_q88_if.sv
// Upstream/downstream handshake and statistics bundle for acc_requant_q88.
interface acc_requant_q88_if #(
    parameter int ACC_WIDTH   = 32,
    parameter int DATA_WIDTH  = 16,
    parameter int SHIFT_WIDTH = 5,
    parameter int CNT_WIDTH   = 16
);
    logic [ACC_WIDTH-1:0]   acc_in;
    logic [DATA_WIDTH-1:0]  bias_in;
    logic [SHIFT_WIDTH-1:0] shift_amt;
    logic                   valid_in;
    logic                   ready_out;
    logic [DATA_WIDTH-1:0]  data_out;
    logic                   valid_out;
    logic                   ready_in;
    logic                   sat_flag;
    logic [CNT_WIDTH-1:0]   sat_count;
    logic                   clr_count;

    // Block-side view.
    modport slave (
        input  acc_in, bias_in, shift_amt, valid_in, ready_in, clr_count,
        output ready_out, data_out, valid_out, sat_flag, sat_count
    );

    // Driver/consumer-side view.
    modport master (
        output acc_in, bias_in, shift_amt, valid_in, ready_in, clr_count,
        input  ready_out, data_out, valid_out, sat_flag, sat_count
    );
endinterface

// File: rtl/acc_requant_q88_round_sat.sv
// Combinational round-half-up, arithmetic right shift and Q8.8 saturation.
// Saturation flag output exists only when REQUANT_SAT_STATS_EN is defined.
module requant_round_sat
    import acc_requant_q88_pkg::*;
#(
    parameter int SUM_W       = 58,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic signed [SUM_W-1:0]       sum_i,
    input  logic        [SHIFT_WIDTH-1:0] shift_i,
`ifdef REQUANT_SAT_STATS_EN
    output logic                          sat_o,
`endif
    output logic        [Q88_WIDTH-1:0]   data_o
);

    logic signed [SUM_W-1:0]    half;
    logic signed [SUM_W-1:0]    rounded;
    logic signed [SUM_W-1:0]    shifted;
    logic signed [SAT_IN_W-1:0] wide;

    always_comb begin
        half = '0;
        if (shift_i != '0) begin
            half = SUM_W'(1) << (shift_i - 1'b1);
        end
        rounded = sum_i + half;
        shifted = rounded >>> shift_i;
        wide    = {{(SAT_IN_W-SUM_W){shifted[SUM_W-1]}}, shifted};
    end

    assign data_o = sat_q88(wide);
`ifdef REQUANT_SAT_STATS_EN
    assign sat_o  = q88_clips(wide);
`endif

endmodule

// File: rtl/acc_requant_q88.sv
// Two-stage accumulator requantiser: bias add, round/shift to Q8.8, saturate, with backpressure.
// Build option REQUANT_SAT_STATS_EN enables sat_flag and the saturation counter.
module acc_requant_q88
    import acc_requant_q88_pkg::*;
#(
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int DATA_WIDTH  = 16,
    parameter int SHIFT_WIDTH = 5,
    parameter int MAX_SHIFT   = 24,
    parameter int CNT_WIDTH   = 16
) (
    input logic                clk,
    input logic                rst,
    acc_requant_q88_if.slave   bus
);

    // Wide enough that the shifted bias plus accumulator can never wrap.
    localparam int SUM_W = ACC_WIDTH + MAX_SHIFT + 2;
    localparam logic [SHIFT_WIDTH-1:0] MAX_SHIFT_L = SHIFT_WIDTH'(MAX_SHIFT);

    logic                          advance;
    logic                          s1_valid_q;
    logic signed [SUM_W-1:0]       s1_sum_q, s1_sum_d;
    logic        [SHIFT_WIDTH-1:0] s1_shift_q, s1_shift_d;
    logic signed [SUM_W-1:0]       acc_ext, bias_ext;
    logic                          valid_out_q;
    logic        [DATA_WIDTH-1:0]  data_out_q;
    logic        [Q88_WIDTH-1:0]   rs_data;

    assign advance       = !(valid_out_q && !bus.ready_in);
    assign bus.ready_out = advance;
    assign bus.valid_out = valid_out_q;
    assign bus.data_out  = data_out_q;

    always_comb begin
        s1_shift_d = (bus.shift_amt > MAX_SHIFT_L) ? MAX_SHIFT_L : bus.shift_amt;
        acc_ext    = {{(SUM_W-ACC_WIDTH){bus.acc_in[ACC_WIDTH-1]}}, bus.acc_in};
        bias_ext   = {{(SUM_W-DATA_WIDTH){bus.bias_in[DATA_WIDTH-1]}}, bus.bias_in};
        s1_sum_d   = acc_ext + (bias_ext << s1_shift_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_shift_q <= '0;
        end else if (advance) begin
            s1_valid_q <= bus.valid_in;
            if (bus.valid_in) begin
                s1_sum_q   <= s1_sum_d;
                s1_shift_q <= s1_shift_d;
            end
        end
    end

`ifdef REQUANT_SAT_STATS_EN
    logic                 rs_sat;
    logic                 sat_flag_q;
    logic [CNT_WIDTH-1:0] sat_count_q, sat_count_d;

    requant_round_sat #(
        .SUM_W       (SUM_W),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_round_sat (
        .sum_i   (s1_sum_q),
        .shift_i (s1_shift_q),
        .sat_o   (rs_sat),
        .data_o  (rs_data)
    );
`else
    requant_round_sat #(
        .SUM_W       (SUM_W),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_round_sat (
        .sum_i   (s1_sum_q),
        .shift_i (s1_shift_q),
        .data_o  (rs_data)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
`ifdef REQUANT_SAT_STATS_EN
            sat_flag_q  <= 1'b0;
`endif
        end else if (advance) begin
            valid_out_q <= s1_valid_q;
            if (s1_valid_q) begin
                data_out_q <= DATA_WIDTH'(rs_data);
`ifdef REQUANT_SAT_STATS_EN
                sat_flag_q <= rs_sat;
`endif
            end
        end
    end

`ifdef REQUANT_SAT_STATS_EN
    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        sat_count_d = sat_count_q;
        if (bus.clr_count) begin
            sat_count_d = '0;
        end else if (valid_out_q && bus.ready_in && sat_flag_q && !(&sat_count_q)) begin
            sat_count_d = sat_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
        end
    end

    assign bus.sat_flag  = sat_flag_q;
    assign bus.sat_count = sat_count_q;
`else
    assign bus.sat_flag  = 1'b0;
    assign bus.sat_count = '0;
`endif

endmodule

// File: tb/tb_acc_requant_q88.sv
// Directed self-checking bench for acc_requant_q88; expectations follow REQUANT_SAT_STATS_EN.
module tb_acc_requant_q88;

`ifdef REQUANT_SAT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    acc_requant_q88_if bus_if ();

    acc_requant_q88 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached (got timeout, want completion)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated sample: 2-cycle latency, single-cycle valid_out pulse with ready_in high.
    task automatic run_single(input string tag, input logic [31:0] acc, input logic [15:0] bias,
                              input logic [4:0] shift, input logic [15:0] exp_data, input logic exp_sat);
        bus_if.ready_in  = 1'b1;
        bus_if.valid_in  = 1'b1;
        bus_if.acc_in    = acc;
        bus_if.bias_in   = bias;
        bus_if.shift_amt = shift;
        tick();
        bus_if.valid_in  = 1'b0;
        tick();
        check({tag, "_valid"}, 32'(bus_if.valid_out), 32'd1);
        check({tag, "_data"}, 32'(bus_if.data_out), 32'(exp_data));
        check({tag, "_sat"}, 32'(bus_if.sat_flag), 32'(exp_sat & STATS));
        $display("[TB] %s acc=0x%08h bias=0x%04h shift=%0d -> data=0x%04h sat=%0b",
                 tag, acc, bias, shift, bus_if.data_out, bus_if.sat_flag);
        tick();
        check({tag, "_pulse"}, 32'(bus_if.valid_out), 32'd0);
    endtask

    logic [31:0] bp_acc [8];
    logic [15:0] bp_exp [8];

    initial begin
        int n_in;
        int n_out;
        logic stalled_prev;
        logic [15:0] held;

        tests_run    = 0;
        tests_failed = 0;
        rst              = 1'b1;
        bus_if.acc_in    = '0;
        bus_if.bias_in   = '0;
        bus_if.shift_amt = '0;
        bus_if.valid_in  = 1'b0;
        bus_if.ready_in  = 1'b1;
        bus_if.clr_count = 1'b0;

        bp_acc = '{32'h0111, 32'h0222, 32'h0333, 32'h0444, 32'h0555, 32'h0666, 32'h0777, 32'h0888};
        bp_exp = '{16'h0111, 16'h0222, 16'h0333, 16'h0444, 16'h0555, 16'h0666, 16'h0777, 16'h0888};

        // Reset state
        tick();
        check("rst_valid_out", 32'(bus_if.valid_out), 32'd0);
        check("rst_data_out", 32'(bus_if.data_out), 32'd0);
        check("rst_sat_flag", 32'(bus_if.sat_flag), 32'd0);
        check("rst_sat_count", 32'(bus_if.sat_count), 32'd0);
        check("rst_ready_out", 32'(bus_if.ready_out), 32'd1);
        tick();
        rst = 1'b0;
        tick();

        // Rounding, bias, clamp and range boundaries
        run_single("round_0180", 32'h0000_0180, 16'h0000, 5'd4,  16'h0018, 1'b0);
        run_single("round_half", 32'h0000_0188, 16'h0000, 5'd4,  16'h0019, 1'b0);
        run_single("round_neg",  32'hFFFF_FE78, 16'h0000, 5'd4,  16'hFFE8, 1'b0);
        run_single("bias_s0",    32'h0000_0100, 16'h0080, 5'd0,  16'h0180, 1'b0);
        run_single("bias_s8",    32'h0000_0000, 16'h0100, 5'd8,  16'h0100, 1'b0);
        run_single("shift_clamp",32'h0100_0000, 16'h0000, 5'd31, 16'h0001, 1'b0);
        run_single("edge_max",   32'h0000_7FFF, 16'h0000, 5'd0,  16'h7FFF, 1'b0);
        run_single("edge_min",   32'hFFFF_8000, 16'h0000, 5'd0,  16'h8000, 1'b0);
        check("cnt_none", 32'(bus_if.sat_count), 32'd0);

        // Saturation
        run_single("sat_pos",    32'h7FFF_FFFF, 16'h0000, 5'd8,  16'h7FFF, 1'b1);
        run_single("sat_neg",    32'h8000_0000, 16'h0000, 5'd8,  16'h8000, 1'b1);
        check("cnt_two", 32'(bus_if.sat_count), STATS ? 32'd2 : 32'd0);
        run_single("sat_bias",   32'h0000_0100, 16'h7FFF, 5'd0,  16'h7FFF, 1'b1);
        run_single("sat_edge",   32'h0000_8000, 16'h0000, 5'd0,  16'h7FFF, 1'b1);
        check("cnt_four", 32'(bus_if.sat_count), STATS ? 32'd4 : 32'd0);

        // Backpressure: ready_in low in cycles 3..6 of an 8-sample stream
        n_in = 0;
        n_out = 0;
        stalled_prev = 1'b0;
        held = '0;
        bus_if.bias_in   = '0;
        bus_if.shift_amt = '0;
        for (int c = 0; c < 40; c++) begin
            bus_if.ready_in = !(c >= 3 && c <= 6);
            if (n_in < 8) begin
                bus_if.valid_in = 1'b1;
                bus_if.acc_in   = bp_acc[n_in];
            end else begin
                bus_if.valid_in = 1'b0;
            end
            #1;
            if (bus_if.valid_out && !bus_if.ready_in) begin
                check("bp_ready_low", 32'(bus_if.ready_out), 32'd0);
            end else begin
                check("bp_ready_high", 32'(bus_if.ready_out), 32'd1);
            end
            if (stalled_prev) begin
                check("bp_hold", 32'(bus_if.data_out), 32'(held));
                check("bp_hold_valid", 32'(bus_if.valid_out), 32'd1);
            end
            if (bus_if.valid_out && bus_if.ready_in) begin
                if (n_out < 8) begin
                    check("bp_order", 32'(bus_if.data_out), 32'(bp_exp[n_out]));
                end
                $display("[TB] bp out %0d data=0x%04h cycle=%0d", n_out, bus_if.data_out, c);
                n_out++;
            end
            stalled_prev = bus_if.valid_out && !bus_if.ready_in;
            held = bus_if.data_out;
            if (bus_if.valid_in && bus_if.ready_out) n_in++;
            if (n_in == 8 && n_out == 8) break;
            @(posedge clk);
            #1;
        end
        check("bp_in_count", 32'(n_in), 32'd8);
        check("bp_out_count", 32'(n_out), 32'd8);
        bus_if.valid_in = 1'b0;
        bus_if.ready_in = 1'b1;
        tick();
        check("bp_drained", 32'(bus_if.valid_out), 32'd0);

        // Reset with both stages full and the output stalled
        bus_if.ready_in  = 1'b0;
        bus_if.valid_in  = 1'b1;
        bus_if.acc_in    = 32'h0000_0500;
        tick();
        tick();
        tick();
        check("pre_rst_full", 32'(bus_if.valid_out), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_valid_out", 32'(bus_if.valid_out), 32'd0);
        check("arst_data_out", 32'(bus_if.data_out), 32'd0);
        check("arst_sat_count", 32'(bus_if.sat_count), 32'd0);
        bus_if.valid_in = 1'b0;
        bus_if.ready_in = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_empty", 32'(bus_if.valid_out), 32'd0);
        tick();
        check("post_rst_empty2", 32'(bus_if.valid_out), 32'd0);
        run_single("post_rst", 32'h0000_0300, 16'h0000, 5'd0, 16'h0300, 1'b0);

        // Counter saturation: 0xFFFF+2 saturating transfers
        bus_if.ready_in  = 1'b1;
        bus_if.valid_in  = 1'b1;
        bus_if.acc_in    = 32'h7FFF_FFFF;
        bus_if.bias_in   = 16'h0000;
        bus_if.shift_amt = 5'd8;
        repeat (65537) tick();
        bus_if.valid_in = 1'b0;
        tick();
        tick();
        tick();
        check("cnt_stick", 32'(bus_if.sat_count), STATS ? 32'h0000_FFFF : 32'd0);
        $display("[TB] counter after 65537 saturating transfers = 0x%04h", bus_if.sat_count);

        // clr_count coinciding with a saturating output transfer
        bus_if.valid_in = 1'b1;
        tick();
        bus_if.valid_in = 1'b0;
        tick();
        check("clr_sat_valid", 32'(bus_if.valid_out), 32'd1);
        check("clr_sat_flag", 32'(bus_if.sat_flag), 32'(STATS));
        bus_if.clr_count = 1'b1;
        tick();
        bus_if.clr_count = 1'b0;
        check("clr_priority", 32'(bus_if.sat_count), 32'd0);
        run_single("after_clr", 32'h8000_0000, 16'h0000, 5'd8, 16'h8000, 1'b1);
        check("cnt_after_clr", 32'(bus_if.sat_count), STATS ? 32'd1 : 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
